starfield_layers: RTL and testbench

Multi-layer parallax starfield generator for the VGA display pipeline. It runs `LAYERS` independent Galois LFSRs, one per star layer. Each layer has its own seed, per-frame drift, and brightness attenuation, and outputs the front-most visible star per pixel. It sits between the display timing generator and the VGA output registers. The caller supplies the per-pixel step enable (active area AND `de`) and receives a registered star/brightness result.

---
 rtl/starfield_layers.sv | 133 +++++++++++++
 tb/tb_starfield_layers.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/starfield_layers.sv
// Multi-layer parallax starfield: one Galois LFSR per layer, each reloaded from its seed
// on its own wrap period so the pattern drifts by INCS steps per frame.
module starfield_layers #(
  parameter int                    LAYERS  = 3,
  parameter int                    LEN     = 17,
  parameter logic [LEN-1:0]        TAPS    = 17'b10010000000000000,
  parameter logic [LAYERS*LEN-1:0] SEEDS   = '0,
  parameter int                    H       = 512,
  parameter int                    V       = 256,
  parameter logic [LAYERS*16-1:0]  INCS    = 48'hFFFF_FFFE_FFFC,
  parameter int                    DENSITY = 8
) (
  input  logic                                clk_pix,
  input  logic                                rst_pix,
  input  logic                                en,
  input  logic                                restart,
  output logic                                star,
  output logic [(LAYERS > 1 ? $clog2(LAYERS) : 1)-1:0] star_layer,
  output logic [3:0]                          star_bright
);

  localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;

  function automatic logic [LEN-1:0] seed_of(input int k);
    logic [LEN-1:0] s;
    s = SEEDS[k*LEN +: LEN];
    return (s == '0) ? '1 : s;
  endfunction

  function automatic logic signed [31:0] rst_cnt_of(input int k);
    logic signed [15:0] inc;
    logic signed [31:0] r;
    inc = INCS[k*16 +: 16];
    r   = H * V;
    return r + inc;
  endfunction

  logic [LAYERS-1:0] hit;
  logic [3:0]        bright [LAYERS];

  for (genvar k = 0; k < LAYERS; k++) begin : g_layer
    localparam logic [LEN-1:0]     SEED    = seed_of(k);
    localparam logic signed [31:0] RST_CNT = rst_cnt_of(k);
    localparam logic [31:0]        LAST    = RST_CNT - 1;

    if (RST_CNT < 2) begin : g_bad_period
      $error("starfield_layers: wrap period of a layer is below 2");
    end

    logic [LEN-1:0] sreg_q, sreg_d;
    logic [31:0]    cnt_q, cnt_d;

    always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      if (restart) begin
        sreg_d = SEED;
        cnt_d  = '0;
      end else if (en) begin
        if (cnt_q == LAST) begin
          sreg_d = SEED;
          cnt_d  = '0;
        end else begin
          sreg_d = sreg_q[0] ? ((sreg_q >> 1) ^ TAPS) : (sreg_q >> 1);
          cnt_d  = cnt_q + 32'd1;
        end
      end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
        sreg_q <= SEED;
        cnt_q  <= '0;
      end else begin
        sreg_q <= sreg_d;
        cnt_q  <= cnt_d;
      end
    end

    // Star test and brightness use the pre-step value; far layers are dimmer.
    assign hit[k]    = &sreg_q[LEN-1 -: DENSITY];
    assign bright[k] = sreg_q[3:0] >> k;
  end

  logic          any_hit;
  logic [LW-1:0] win_layer;
  logic [3:0]    win_bright;

  always_comb begin
    any_hit    = 1'b0;
    win_layer  = '0;
    win_bright = '0;
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (hit[k]) begin
        any_hit    = 1'b1;
        win_layer  = LW'(k);
        win_bright = bright[k];
      end
    end
  end

  logic          star_q, star_d;
  logic [LW-1:0] layer_q, layer_d;
  logic [3:0]    bright_q, bright_d;

  always_comb begin
    star_d   = 1'b0;
    layer_d  = '0;
    bright_d = '0;
    if (en && !restart && any_hit) begin
      star_d   = 1'b1;
      layer_d  = win_layer;
      bright_d = win_bright;
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      star_q   <= 1'b0;
      layer_q  <= '0;
      bright_q <= '0;
    end else begin
      star_q   <= star_d;
      layer_q  <= layer_d;
      bright_q <= bright_d;
    end
  end

  assign star        = star_q;
  assign star_layer  = layer_q;
  assign star_bright = bright_q;

endmodule

// File: tb/tb_starfield_layers.sv
// Directed bench for starfield_layers: several parameterisations share clock, reset and controls.
module tb_starfield_layers;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic restart = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic       sA, sB, sC, sD, sE, sF, sG;
  logic [1:0] lA, lE, lF;
  logic       lB, lC, lD, lG;
  logic [3:0] bA, bB, bC, bD, bE, bF, bG;

  // Default: 3 layers, all-ones seeds, 512x256
  starfield_layers dA (.clk_pix(clk), .rst_pix(rst), .en(en), .restart(restart),
                       .star(sA), .star_layer(lA), .star_bright(bA));
  // Wrap period 9
  starfield_layers #(.LAYERS(1), .H(4), .V(2), .INCS(16'h0001))
    dB (.clk_pix(clk), .rst_pix(rst), .en(en), .restart(restart),
        .star(sB), .star_layer(lB), .star_bright(bB));
  // Static layer, period 8
  starfield_layers #(.LAYERS(1), .H(4), .V(2), .INCS(16'h0000))
    dC (.clk_pix(clk), .rst_pix(rst), .en(en), .restart(restart),
        .star(sC), .star_layer(lC), .star_bright(bC));
  // Drift -1, period 7
  starfield_layers #(.LAYERS(1), .H(4), .V(2), .INCS(16'hFFFF))
    dD (.clk_pix(clk), .rst_pix(rst), .en(en), .restart(restart),
        .star(sD), .star_layer(lD), .star_bright(bD));
  // Layer 0 seeded with 1: layer 1 wins
  starfield_layers #(.SEEDS({17'h0, 17'h0, 17'h00001}))
    dE (.clk_pix(clk), .rst_pix(rst), .en(en), .restart(restart),
        .star(sE), .star_layer(lE), .star_bright(bE));
  // Layers 0 and 1 seeded with 1: layer 2 wins
  starfield_layers #(.SEEDS({17'h0, 17'h00001, 17'h00001}))
    dF (.clk_pix(clk), .rst_pix(rst), .en(en), .restart(restart),
        .star(sF), .star_layer(lF), .star_bright(bF));
  // Hit with zero brightness
  starfield_layers #(.LAYERS(1), .SEEDS(17'h1FF00))
    dG (.clk_pix(clk), .rst_pix(rst), .en(en), .restart(restart),
        .star(sG), .star_layer(lG), .star_bright(bG));

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; en = 1'b0; restart = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input logic e, input logic r);
    @(negedge clk);
    en = e; restart = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({sA, lA, bA} !== 7'd0) begin
      errors++; $display("FAIL reset_idle: got %h required 0", {sA, lA, bA});
    end
    step(1'b1, 1'b0);
    checks++;
    if ({sA, lA, bA} !== {1'b1, 2'd0, 4'hF}) begin
      errors++; $display("FAIL first_out: got %b/%0d/%h required 1/0/f", sA, lA, bA);
    end
    checks++;
    if (dA.g_layer[0].sreg_q !== 17'h1DFFF) begin
      errors++; $display("FAIL sreg_step1: got %h required 1dfff", dA.g_layer[0].sreg_q);
    end
    step(1'b1, 1'b0);
    checks++;
    if (dA.g_layer[0].sreg_q !== 17'h1CFFF) begin
      errors++; $display("FAIL sreg_step2: got %h required 1cfff", dA.g_layer[0].sreg_q);
    end
    checks++;
    if (sA !== 1'b0) begin
      errors++; $display("FAIL second_out: got %b required 0", sA);
    end
    // Async assertion mid-stream: bring outputs up first, then reset between edges
    do_reset();
    step(1'b1, 1'b0);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({sE, lE, bE} !== 7'd0) begin
      errors++; $display("FAIL async_reset: got %b/%0d/%h required 0/0/0", sE, lE, bE);
    end
    checks++;
    if (dA.g_layer[0].sreg_q !== 17'h1FFFF) begin
      errors++; $display("FAIL reset_seed: got %h required 1ffff", dA.g_layer[0].sreg_q);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0);
    checks++;
    if ({sA, lA, bA} !== {1'b1, 2'd0, 4'hF}) begin
      errors++; $display("FAIL post_reset_out: got %b/%0d/%h required 1/0/f", sA, lA, bA);
    end
  endtask

  task automatic test_priority;
    do_reset();
    step(1'b1, 1'b0);
    checks++;
    if ({sE, lE, bE} !== {1'b1, 2'd1, 4'h7}) begin
      errors++; $display("FAIL prio_layer1: got %b/%0d/%h required 1/1/7", sE, lE, bE);
    end
    checks++;
    if ({sF, lF, bF} !== {1'b1, 2'd2, 4'h3}) begin
      errors++; $display("FAIL prio_layer2: got %b/%0d/%h required 1/2/3", sF, lF, bF);
    end
    checks++;
    if ({sG, lG, bG} !== {1'b1, 1'b0, 4'h0}) begin
      errors++; $display("FAIL zero_bright_hit: got %b/%0d/%h required 1/0/0", sG, lG, bG);
    end
  endtask

  task automatic test_wrap;
    logic exp;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0);
      exp = (i == 1) || (i == 10);
      checks++;
      if (sB !== exp || (exp && bB !== 4'hF)) begin
        errors++; $display("FAIL wrap_out%0d: got %b/%h required %b/f", i, sB, bB, exp);
      end
    end
  endtask

  task automatic test_static_drift;
    logic expC, expD;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0);
      expC = (i == 1) || (i == 9);
      expD = (i == 1) || (i == 8) || (i == 15);
      checks++;
      if (sC !== expC) begin
        errors++; $display("FAIL static_out%0d: got %b required %b", i, sC, expC);
      end
      checks++;
      if (sD !== expD) begin
        errors++; $display("FAIL drift_out%0d: got %b required %b", i, sD, expD);
      end
    end
  endtask

  task automatic test_restart;
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if ({sA, lA, bA} !== 7'd0) begin
      errors++; $display("FAIL restart_out: got %b/%0d/%h required 0/0/0", sA, lA, bA);
    end
    checks++;
    if (dA.g_layer[2].sreg_q !== 17'h1FFFF) begin
      errors++; $display("FAIL restart_seed: got %h required 1ffff", dA.g_layer[2].sreg_q);
    end
    step(1'b1, 1'b0);
    checks++;
    if ({sA, lA, bA} !== {1'b1, 2'd0, 4'hF}) begin
      errors++; $display("FAIL restart_next: got %b/%0d/%h required 1/0/f", sA, lA, bA);
    end
  endtask

  task automatic test_enable_gating;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({sB, bB} !== 5'd0) begin
        errors++; $display("FAIL gated_out%0d: got %b/%h required 0/0", i, sB, bB);
      end
    end
    checks++;
    if (dA.g_layer[0].sreg_q !== 17'h1C3FF) begin
      errors++; $display("FAIL gated_hold: got %h required 1c3ff", dA.g_layer[0].sreg_q);
    end
    for (int i = 5; i <= 10; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (sB !== (i == 10)) begin
        errors++; $display("FAIL resume_out%0d: got %b required %b", i, sB, (i == 10));
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    checks++;
    if ({sA, lA, bA} !== {1'b1, 2'd0, 4'hF}) begin
      errors++; $display("FAIL b2b_out: got %b/%0d/%h required 1/0/f", sA, lA, bA);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_wrap();
    test_static_drift();
    test_restart();
    test_enable_gating();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
